mxm_relu_sequencer: RTL

- Controller that sequences the streaming MxM_ReLu datapath for one full (MxN)x(NxP) product.
- Generates read addresses for the A and X operand memories and drives the datapath clear.
- Generates write enable and address for the Y result memory.
- Sits between a host start/done handshake and the operand/result RAMs. Memory read data and datapath Y are wired externally; this block carries no data, only control.

---
 rtl/mxm_relu_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mxm_relu_sequencer.sv
// Control sequencer for the streaming MxM_ReLu datapath: operand read addressing,
// datapath clear and Y write scheduling for one (MxN)x(NxP) product.
module mxm_relu_sequencer #(
  parameter int M    = 10,
  parameter int N    = 8,
  parameter int P    = 6,
  parameter int YLAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     rd_en,
  output logic [$clog2(M*N)-1:0]   a_addr,
  output logic [$clog2(N*P)-1:0]   x_addr,
  output logic                     dp_rst,
  output logic                     y_we,
  output logic [$clog2(M*P)-1:0]   y_addr
);

  localparam int AW = $clog2(M*N);
  localparam int XW = $clog2(N*P);
  localparam int YW = $clog2(M*P);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = YLAT + 1;

  localparam logic [AW-1:0] A_LAST = AW'(M*N-1);
  localparam logic [XW-1:0] X_LAST = XW'(N*P-1);
  localparam logic [XW-1:0] X_STEP = XW'(N);
  localparam logic [YW-1:0] Y_LAST = YW'(M*P-1);
  localparam logic [NW-1:0] N_LAST = NW'(N-1);

  // IDLE wait start | CLEAR clear datapath | STREAM issue reads | DRAIN await last Y write | DONE pulse done
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t state, state_next;

  logic [NW-1:0] n, n_next;
  logic [XW-1:0] x_base, x_base_next;
  logic [AW-1:0] a_next;
  logic [XW-1:0] x_next;
  logic [PW-1:0] wr_pipe;
  logic          row_end, issue_last, abort_take;

  assign row_end    = (n == N_LAST);
  assign issue_last = row_end && (a_addr == A_LAST) && (x_addr == X_LAST);
  assign abort_take = abort && (state inside {S_CLEAR, S_STREAM, S_DRAIN});
  assign y_we       = wr_pipe[YLAT];

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start && !abort) state_next = S_CLEAR;
      S_CLEAR:  state_next = S_STREAM;
      S_STREAM: if (issue_last) state_next = S_DRAIN;
      S_DRAIN:  if (y_we && (y_addr == Y_LAST)) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (abort_take) state_next = S_IDLE;
  end

  // a_addr walks 0..M*N-1 once per p; x_addr restarts at p*N on every row end
  always_comb begin
    n_next      = n + 1'b1;
    a_next      = a_addr + 1'b1;
    x_next      = x_addr + 1'b1;
    x_base_next = x_base;
    if (row_end) begin
      n_next = '0;
      if (a_addr == A_LAST) begin
        a_next      = '0;
        x_base_next = (x_addr == X_LAST) ? '0 : x_base + X_STEP;
        x_next      = x_base_next;
      end else begin
        x_next = x_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      n       <= '0;
      x_base  <= '0;
      a_addr  <= '0;
      x_addr  <= '0;
      y_addr  <= '0;
      wr_pipe <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      rd_en   <= 1'b0;
      dp_rst  <= 1'b1;
    end else begin
      state   <= state_next;
      busy    <= (state_next != S_IDLE);
      done    <= (state_next == S_DONE);
      aborted <= abort_take;
      rd_en   <= (state_next == S_STREAM);
      dp_rst  <= (state_next inside {S_IDLE, S_CLEAR});

      if (state_next != S_STREAM) begin
        n      <= '0;
        x_base <= '0;
        a_addr <= '0;
        x_addr <= '0;
      end else if (state == S_STREAM) begin
        n      <= n_next;
        x_base <= x_base_next;
        a_addr <= a_next;
        x_addr <= x_next;
      end

      // last element of a dot product enters the pipe, emerges YLAT+1 cycles later
      if (state_next == S_IDLE) begin
        wr_pipe <= '0;
        y_addr  <= '0;
      end else begin
        wr_pipe <= (wr_pipe << 1) | PW'(state == S_STREAM && row_end);
        if (y_we && (y_addr != Y_LAST)) y_addr <= y_addr + 1'b1;
      end
    end
  end

endmodule
